pwm_gpio34: RTL and testbench

- Two-channel 7-bit PWM generator driving pads GPIO3 (channel 0) and GPIO4 (channel 1).
- Holds three SFRs, written by the SFR bus of the I2C slave or CPU: X0_PWM0, X0_PWM1 and GPIO34.
- Produces pad data-out and output-enable per pin; the pad cell sits outside this block.

---
 rtl/pwm_gpio34_pkg.sv | 19 +
 rtl/pwm_chan.sv | 52 +++++
 rtl/pwm_gpio34.sv | 96 +++++++++
 tb/tb_pwm_gpio34.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_gpio34_pkg.sv
// Shared SFR layout and phase width for the two-channel GPIO3/GPIO4 PWM block.
package pwm_gpio34_pkg;

  localparam int unsigned PH_W = 7;

  localparam int unsigned EN_BIT    = 7;
  localparam int unsigned G3_DO_BIT = 0;
  localparam int unsigned G3_OE_BIT = 2;
  localparam int unsigned G4_DO_BIT = 4;
  localparam int unsigned G4_OE_BIT = 6;

  localparam logic [PH_W-1:0] PH_MAX = '1;

  typedef struct packed {
    logic            en;
    logic [PH_W-1:0] duty;
  } pwm_sfr_t;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: X0_PWMn register, period-aligned duty shadow and registered compare.
module pwm_chan
  import pwm_gpio34_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [7:0]      wdat_i,
  input  logic [PH_W-1:0] phase_i,
  input  logic            wrap_i,
  output logic [7:0]      sfr_o,
  output logic            en_o,
  output logic            start_o,
  output logic            pwm_o
);

  pwm_sfr_t        sfr_q, sfr_d, wr_sfr;
  logic [PH_W-1:0] duty_act_q, duty_act_d;
  logic            pwm_q, pwm_d;

  assign wr_sfr  = pwm_sfr_t'(wdat_i);
  assign sfr_d   = we_i ? wr_sfr : sfr_q;
  assign start_o = we_i & wdat_i[EN_BIT] & ~sfr_q.en;

  // A write landing on the wrap edge is seen here through sfr_d.
  always_comb begin
    duty_act_d = duty_act_q;
    if (wrap_i || start_o) begin
      duty_act_d = sfr_d.duty;
    end
  end

  // sfr_d.en kills the output on the same edge a disabling write lands.
  assign pwm_d = sfr_q.en & sfr_d.en & (phase_i < duty_act_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sfr_q      <= '0;
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      sfr_q      <= sfr_d;
      duty_act_q <= duty_act_d;
      pwm_q      <= pwm_d;
    end
  end

  assign sfr_o = sfr_q;
  assign en_o  = sfr_q.en;
  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_gpio34.sv
// Two-channel 7-bit PWM on GPIO3/GPIO4 with GPIO34 fallback data and output-enable register.
module pwm_gpio34
  import pwm_gpio34_pkg::*;
#(
  parameter int unsigned PRESCALE = 16,
  parameter int unsigned PSC_W    = 8
) (
  input  logic       clk,
  input  logic       rstz,
  input  logic [7:0] sfr_wdat,
  input  logic       we_pwm0,
  input  logic       we_pwm1,
  input  logic       we_gpio34,
  output logic [7:0] pwm0_q,
  output logic [7:0] pwm1_q,
  output logic [7:0] gpio34_q,
  output logic       gpio3_do,
  output logic       gpio3_oe,
  output logic       gpio4_do,
  output logic       gpio4_oe
);

  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0] psc_q, psc_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [7:0]       gpio34_d;
  logic             en0, en1, en_any;
  logic             start0, start1, restart;
  logic             tick, wrap;
  logic             pwm0, pwm1;

  assign en_any = en0 | en1;
  assign tick   = en_any & (psc_q == PSC_LAST);
  assign wrap   = tick & (phase_q == PH_MAX);
  // Enabling a channel restarts the shared phase only when the other one is idle.
  assign restart = (start0 & ~en1) | (start1 & ~en0);

  always_comb begin
    psc_d   = psc_q + PSC_W'(1);
    phase_d = phase_q;
    if (!en_any || restart) begin
      psc_d   = '0;
      phase_d = '0;
    end else if (tick) begin
      psc_d   = '0;
      phase_d = phase_q + PH_W'(1);
    end
  end

  assign gpio34_d = we_gpio34 ? sfr_wdat : gpio34_q;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      psc_q    <= '0;
      phase_q  <= '0;
      gpio34_q <= '0;
    end else begin
      psc_q    <= psc_d;
      phase_q  <= phase_d;
      gpio34_q <= gpio34_d;
    end
  end

  pwm_chan u_chan0 (
    .clk_i   (clk),
    .rst_ni  (rstz),
    .we_i    (we_pwm0),
    .wdat_i  (sfr_wdat),
    .phase_i (phase_q),
    .wrap_i  (wrap),
    .sfr_o   (pwm0_q),
    .en_o    (en0),
    .start_o (start0),
    .pwm_o   (pwm0)
  );

  pwm_chan u_chan1 (
    .clk_i   (clk),
    .rst_ni  (rstz),
    .we_i    (we_pwm1),
    .wdat_i  (sfr_wdat),
    .phase_i (phase_q),
    .wrap_i  (wrap),
    .sfr_o   (pwm1_q),
    .en_o    (en1),
    .start_o (start1),
    .pwm_o   (pwm1)
  );

  assign gpio3_do = en0 ? pwm0 : gpio34_q[G3_DO_BIT];
  assign gpio4_do = en1 ? pwm1 : gpio34_q[G4_DO_BIT];
  assign gpio3_oe = gpio34_q[G3_OE_BIT];
  assign gpio4_oe = gpio34_q[G4_OE_BIT];

endmodule

// File: tb/tb_pwm_gpio34.sv
// Directed bench for pwm_gpio34: expectations queued at stimulus time, popped at each check.
module tb_pwm_gpio34;

  localparam int unsigned P   = 4;
  localparam int unsigned PER = 128 * P;

  logic       clk = 1'b0;
  logic       rstz = 1'b0;
  logic [7:0] sfr_wdat = 8'h00;
  logic       we_pwm0 = 1'b0;
  logic       we_pwm1 = 1'b0;
  logic       we_gpio34 = 1'b0;
  logic [7:0] pwm0_q, pwm1_q, gpio34_q;
  logic       gpio3_do, gpio3_oe, gpio4_do, gpio4_oe;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  pwm_gpio34 #(
    .PRESCALE (P),
    .PSC_W    (8)
  ) dut (
    .clk       (clk),
    .rstz      (rstz),
    .sfr_wdat  (sfr_wdat),
    .we_pwm0   (we_pwm0),
    .we_pwm1   (we_pwm1),
    .we_gpio34 (we_gpio34),
    .pwm0_q    (pwm0_q),
    .pwm1_q    (pwm1_q),
    .gpio34_q  (gpio34_q),
    .gpio3_do  (gpio3_do),
    .gpio3_oe  (gpio3_oe),
    .gpio4_do  (gpio4_do),
    .gpio4_oe  (gpio4_oe)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL %s: observed %0h, scoreboard empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
    end
  endtask

  task automatic wr(input int sel, input logic [7:0] d);
    @(negedge clk);
    sfr_wdat = d;
    case (sel)
      0:       we_pwm0 = 1'b1;
      1:       we_pwm1 = 1'b1;
      default: we_gpio34 = 1'b1;
    endcase
    @(negedge clk);
    we_pwm0   = 1'b0;
    we_pwm1   = 1'b0;
    we_gpio34 = 1'b0;
  endtask

  function automatic logic pad(input bit ch);
    return ch ? gpio4_do : gpio3_do;
  endfunction

  task automatic count_hi(input int n, output int h3, output int h4);
    h3 = 0;
    h4 = 0;
    repeat (n) begin
      @(negedge clk);
      h3 += int'(gpio3_do);
      h4 += int'(gpio4_do);
    end
  endtask

  // Waits for pad ch to change to lvl; prev_other is the other pad one sample earlier.
  task automatic wait_edge(input bit ch, input logic lvl, input int budget,
                           output bit ok, output logic prev_other);
    logic prev, oth;
    ok = 1'b0;
    prev = pad(ch);
    prev_other = pad(!ch);
    for (int i = 0; i < budget; i++) begin
      oth = pad(!ch);
      @(negedge clk);
      if (pad(ch) === lvl && prev !== lvl) begin
        ok = 1'b1;
        prev_other = oth;
        return;
      end
      prev = pad(ch);
    end
  endtask

  task automatic run_len(input bit ch, input logic lvl, output int len);
    len = 0;
    while (pad(ch) === lvl && len < 2 * PER) begin
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    bit   ok;
    logic po;
    int   h3, h4, len, c;

    repeat (3) @(negedge clk);
    expect_val(32'h0);
    check("rst_readback", {pwm0_q, pwm1_q, gpio34_q});
    expect_val(32'h0);
    check("rst_pads", {gpio3_do, gpio3_oe, gpio4_do, gpio4_oe});
    rstz = 1'b1;

    // GPIO34 = 0x44: both OE on, data low
    wr(2, 8'h44);
    expect_val(32'h44);
    check("gpio34_rb_44", gpio34_q);
    expect_val(32'b0101);
    check("pads_44", {gpio3_do, gpio3_oe, gpio4_do, gpio4_oe});

    // Duty 0 on ch0, duty 127 on ch1
    wr(0, 8'h80);
    wr(1, 8'hFF);
    expect_val(32'h80);
    check("pwm0_rb_80", pwm0_q);
    expect_val(32'hFF);
    check("pwm1_rb_ff", pwm1_q);
    wait_edge(1'b1, 1'b1, PER + 8, ok, po);
    expect_val(32'h1);
    check("gpio4_rise_127", ok);
    count_hi(10 * PER, h3, h4);
    expect_val(32'h0);
    check("gpio3_duty0_10p", h3);
    expect_val(10 * 127 * P);
    check("gpio4_duty127_10p", h4);
    wait_edge(1'b1, 1'b0, PER + 8, ok, po);
    expect_val(32'h1);
    check("gpio4_fall_127", ok);
    run_len(1'b1, 1'b0, len);
    expect_val(P);
    check("gpio4_low_run", len);
    run_len(1'b1, 1'b1, len);
    expect_val(127 * P);
    check("gpio4_high_run", len);

    // Duty 15 / 32 take effect at the next period boundary
    wr(0, 8'h8F);
    wr(1, 8'hA0);
    expect_val(32'h8F);
    check("pwm0_rb_8f", pwm0_q);
    expect_val(32'hA0);
    check("pwm1_rb_a0", pwm1_q);
    repeat (PER + 2 * P) @(negedge clk);
    wait_edge(1'b0, 1'b1, PER + 8, ok, po);
    expect_val(32'h1);
    check("gpio3_rise_15", ok);
    expect_val(32'b01);
    check("rise_together", {po, gpio4_do});
    count_hi(PER, h3, h4);
    expect_val(15 * P);
    check("gpio3_duty15", h3);
    expect_val(32 * P);
    check("gpio4_duty32", h4);

    // Mid-period duty change on ch1 waits for the wrap
    wait_edge(1'b1, 1'b1, PER + 8, ok, po);
    expect_val(32'h1);
    check("gpio4_rise_32", ok);
    len = 0;
    c = 0;
    while (gpio4_do && len < 2 * PER) begin
      len++;
      @(negedge clk);
      c++;
      if (c == 10 * P) begin
        sfr_wdat = 8'h90;
        we_pwm1  = 1'b1;
      end else begin
        we_pwm1 = 1'b0;
      end
    end
    we_pwm1 = 1'b0;
    expect_val(32 * P);
    check("gpio4_cur_period_32", len);
    expect_val(32'h90);
    check("pwm1_rb_90", pwm1_q);
    wait_edge(1'b1, 1'b1, PER + 8, ok, po);
    expect_val(32'h1);
    check("gpio4_rise_16", ok);
    run_len(1'b1, 1'b1, len);
    expect_val(16 * P);
    check("gpio4_next_period_16", len);

    // Disable both while high
    wait_edge(1'b0, 1'b1, PER + 8, ok, po);
    expect_val(32'h1);
    check("gpio3_rise_pre_dis", ok);
    wr(0, 8'h00);
    expect_val(32'h0);
    check("gpio3_off_1clk", gpio3_do);
    wr(1, 8'h00);
    expect_val(32'h0);
    check("gpio4_off_1clk", gpio4_do);
    count_hi(5 * PER, h3, h4);
    expect_val(32'h0);
    check("both_off_5p", h3 + h4);
    expect_val(32'h0);
    check("phase_cleared", 32'(dut.phase_q));

    // GPIO fallback and storage-only bits
    wr(2, 8'h11);
    expect_val(32'b1010);
    check("pads_11", {gpio3_do, gpio3_oe, gpio4_do, gpio4_oe});
    wr(2, 8'h55);
    expect_val(32'b1111);
    check("pads_55", {gpio3_do, gpio3_oe, gpio4_do, gpio4_oe});
    wr(2, 8'hAA);
    expect_val(32'hAA);
    check("gpio34_rb_aa", gpio34_q);
    expect_val(32'b0000);
    check("pads_aa", {gpio3_do, gpio3_oe, gpio4_do, gpio4_oe});

    // Asynchronous reset while a channel drives high
    wr(2, 8'h44);
    wr(1, 8'hFF);
    repeat (3 * P) @(negedge clk);
    expect_val(32'h1);
    check("gpio4_high_pre_rst", gpio4_do);
    #2 rstz = 1'b0;
    #1;
    expect_val(32'h0);
    check("async_rst_pads", {gpio3_do, gpio3_oe, gpio4_do, gpio4_oe});
    expect_val(32'h0);
    check("async_rst_readback", {pwm0_q, pwm1_q, gpio34_q});
    @(negedge clk);
    rstz = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
